// File: rtl/sram_rmw_pkg.sv
// Shared types and parity helpers for the SRAM read-modify-write controller.
// The helpers work on a fixed maximum width; callers size-cast in and out.
package sram_rmw_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StMerge = 1'b1
    } state_e;

    localparam int MaxDw = 512;
    localparam int MaxNb = MaxDw / 8;

    // Even parity: the stored bit makes the XOR of byte plus parity zero.
    function automatic logic [MaxNb-1:0] parity_gen(input logic [MaxDw-1:0] data);
        logic [MaxNb-1:0] par;
        par = '0;
        for (int i = 0; i < MaxNb; i++) begin
            par[i] = ^data[8*i +: 8];
        end
        return par;
    endfunction

    function automatic logic [MaxNb-1:0] parity_chk(input logic [MaxDw-1:0] data,
                                                    input logic [MaxNb-1:0] par);
        return parity_gen(data) ^ par;
    endfunction

endpackage

// File: rtl/sram_byte_merge.sv
// Byte-wise merge of new write data over old macro data, with regenerated parity.
module sram_byte_merge
    import sram_rmw_pkg::*;
#(
    parameter int SramDw = 32,
    localparam int NB    = SramDw / 8
) (
    input  logic [SramDw-1:0] old_data,
    input  logic [SramDw-1:0] new_data,
    input  logic [NB-1:0]     be,
    output logic [SramDw-1:0] merged,
    output logic [NB-1:0]     merged_par
);

    for (genvar i = 0; i < NB; i++) begin : g_byte
        assign merged[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end

    assign merged_par = NB'(parity_gen(MaxDw'(merged)));

endmodule

// File: rtl/sram_rmw_ctrl.sv
// Adapter-to-macro bridge: reads and full writes pass through in one cycle,
// partial writes become a pre-read plus a merged write-back. Per-byte even parity.
module sram_rmw_ctrl
    import sram_rmw_pkg::*;
#(
    parameter int SramAw   = 12,
    parameter int SramDw   = 32,
    parameter bit ParityEn = 1'b1,
    localparam int NB      = SramDw / 8,
    localparam int MW      = SramDw + NB
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic              we_i,
    input  logic [SramAw-1:0] addr_i,
    input  logic [SramDw-1:0] wdata_i,
    input  logic [SramDw-1:0] wmask_i,
    output logic [SramDw-1:0] rdata_o,
    output logic              rvalid_o,
    output logic [1:0]        rerror_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [SramAw-1:0] mem_addr_o,
    output logic [MW-1:0]     mem_wdata_o,
    input  logic [MW-1:0]     mem_rdata_i,
    output logic              rmw_err_o
);

    typedef struct packed {
        logic [SramAw-1:0] addr;
        logic [SramDw-1:0] wdata;
        logic [NB-1:0]     be;
    } rmw_req_t;

    state_e   state_q;
    rmw_req_t cap_q;
    logic     rvalid_q;

    logic [NB-1:0]     be;
    logic              unused_wmask;
    logic              wr_full, wr_null;
    logic              acc, rd_fire, wr_fire, rmw_fire, merging;
    logic [SramDw-1:0] rd_data;
    logic [NB-1:0]     rd_par, rd_mis;
    logic [NB-1:0]     wr_par;
    logic [SramDw-1:0] mrg_data;
    logic [NB-1:0]     mrg_par;

    // Only bit 0 of each byte lane of the mask carries meaning.
    for (genvar i = 0; i < NB; i++) begin : g_be
        assign be[i] = wmask_i[8*i];
    end
    assign unused_wmask = ^wmask_i;

    assign wr_full = &be;
    assign wr_null = ~|be;

    assign gnt_o    = rst_ni & (state_q == StIdle);
    assign acc      = gnt_o & req_i;
    assign rd_fire  = acc & ~we_i;
    assign wr_fire  = acc & we_i & wr_full;
    assign rmw_fire = acc & we_i & ~wr_full & ~wr_null;
    assign merging  = rst_ni & (state_q == StMerge);

    assign rd_data = mem_rdata_i[SramDw-1:0];
    assign rd_par  = mem_rdata_i[MW-1:SramDw];
    assign rd_mis  = {NB{ParityEn}} & NB'(parity_chk(MaxDw'(rd_data), MaxNb'(rd_par)));
    assign wr_par  = {NB{ParityEn}} & NB'(parity_gen(MaxDw'(wdata_i)));

    sram_byte_merge #(
        .SramDw (SramDw)
    ) u_merge (
        .old_data   (rd_data),
        .new_data   (cap_q.wdata),
        .be         (cap_q.be),
        .merged     (mrg_data),
        .merged_par (mrg_par)
    );

    // Macro port is combinational so reads and full writes cost no extra cycle.
    always_comb begin
        mem_req_o   = rd_fire | wr_fire | rmw_fire | merging;
        mem_we_o    = wr_fire | merging;
        mem_addr_o  = addr_i;
        mem_wdata_o = {wr_par, wdata_i};
        if (merging) begin
            mem_addr_o  = cap_q.addr;
            mem_wdata_o = {{NB{ParityEn}} & mrg_par, mrg_data};
        end
    end

    // Errors on bytes being overwritten are harmless; only kept bytes count.
    assign rmw_err_o = merging & |(rd_mis & ~cap_q.be);

    // Macro data lands one cycle after the read, aligned with the registered valid.
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rvalid_q ? rd_data : '0;
    assign rerror_o = {rvalid_q & |rd_mis, 1'b0};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cap_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_fire;
            case (state_q)
                StIdle: begin
                    if (rmw_fire) begin
                        cap_q   <= '{addr: addr_i, wdata: wdata_i, be: be};
                        state_q <= StMerge;
                    end
                end
                StMerge: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Scoreboard bench for sram_rmw_ctrl with a behavioural parity-carrying SRAM macro.
module tb_sram_rmw_ctrl;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NB = 4;
    localparam int MW = 36;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req, gnt, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, wmask, rdata;
    logic          rvalid;
    logic [1:0]    rerror;
    logic          mem_req, mem_we, rmw_err;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    sram_rmw_ctrl #(.SramAw(AW), .SramDw(DW), .ParityEn(1'b1)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .wmask_i     (wmask),
        .rdata_o     (rdata),
        .rvalid_o    (rvalid),
        .rerror_o    (rerror),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .rmw_err_o   (rmw_err)
    );

    // Macro model with a backdoor poke port
    logic [MW-1:0] mem [0:4095];
    logic [MW-1:0] mem_rdata_q;
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr;
    logic [MW-1:0] poke_data;
    assign mem_rdata = mem_rdata_q;

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (mem_req) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata_q   <= mem[mem_addr];
        end
    end

    // Reference model
    logic [31:0] ref_data [0:4095];
    bit          ref_bad  [0:4095];

    typedef struct {
        logic [31:0] d;
        logic [1:0]  e;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int wr_cnt = 0, acc_cnt = 0, rmw_cnt = 0, stall_cnt = 0;
    logic [AW-1:0] last_wr_addr;
    logic [MW-1:0] last_wr_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] bpar(input logic [31:0] d);
        logic [3:0] p;
        for (int b = 0; b < NB; b++) p[b] = ^d[8*b +: 8];
        return p;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (sb_q.size() == 0) chk("spurious_rvalid", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rdata", 64'(rdata), 64'(e.d));
                chk("rerror", 64'(rerror), 64'(e.e));
                chk("rd_latency", 64'(cyc), 64'(e.cyc + 1));
            end
        end
        if (mem_req === 1'b1) begin
            acc_cnt <= acc_cnt + 1;
            if (mem_we) begin
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= mem_addr;
                last_wr_data <= mem_wdata;
            end
        end
        if (rmw_err === 1'b1) rmw_cnt <= rmw_cnt + 1;
        if (rst_n && gnt === 1'b0) stall_cnt <= stall_cnt + 1;
    end

    task automatic poke(input logic [AW-1:0] a, input logic [MW-1:0] d);
        @(posedge clk); #1;
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
        ref_data[a] = d[31:0];
        ref_bad[a]  = (d[35:32] != bpar(d[31:0]));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            req = 1'b0; we = 1'b0;
        end
    endtask

    task automatic do_op(input logic w, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [31:0] m, output int gcyc);
        bit ok;
        logic [3:0] b;
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = wd; wmask = m;
        ok = 1'b0;
        gcyc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("gnt_timeout", 64'd0, 64'd1);
            return;
        end
        gcyc = cyc;
        if (!w) begin
            sb_q.push_back('{ref_data[a], ref_bad[a] ? 2'b10 : 2'b00, cyc});
        end else begin
            for (int i = 0; i < NB; i++) b[i] = m[8*i];
            if (b != 4'h0) begin
                for (int i = 0; i < NB; i++)
                    if (b[i]) ref_data[a][8*i +: 8] = wd[8*i +: 8];
                ref_bad[a] = 1'b0;
            end
        end
    endtask

    task automatic rd(input logic [AW-1:0] a);
        int g;
        do_op(1'b0, a, 32'h0, 32'h0, g);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g1, g2, w0, s0, r0, a0;
        logic [31:0] sav;
        rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = '0; wdata = '0; wmask = '0;

        // Reset: outputs quiet even with a request pending
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rerror", 64'(rerror), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rmw_err", 64'(rmw_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; req = 1'b0;

        poke(12'h010, {bpar(32'hDEADBEEF), 32'hDEADBEEF});
        poke(12'h030, {bpar(32'h11223344), 32'h11223344});
        poke(12'h040, {bpar(32'h55667788) ^ 4'b0100, 32'h55667788});
        poke(12'h050, {bpar(32'h99AABBCC) ^ 4'b0100, 32'h99AABBCC});
        poke(12'h060, {bpar(32'hA0B0C0D0), 32'hA0B0C0D0});
        poke(12'h070, {bpar(32'hCAFEF00D), 32'hCAFEF00D});

        // 1: plain read
        rd(12'h010);
        idle(2);

        // 2: full write then read, no stall
        w0 = wr_cnt; s0 = stall_cnt;
        do_op(1'b1, 12'h020, 32'h12345678, 32'hFFFFFFFF, g1);
        rd(12'h020);
        idle(2);
        chk("full_wr_cnt", 64'(wr_cnt - w0), 64'd1);
        chk("full_wr_stall", 64'(stall_cnt - s0), 64'd0);
        chk("full_wr_data", 64'(last_wr_data), 64'({bpar(32'h12345678), 32'h12345678}));

        // 3: partial write merges
        w0 = wr_cnt; s0 = stall_cnt;
        do_op(1'b1, 12'h030, 32'h000000AA, 32'h000000FF, g1);
        idle(2);
        chk("part_wr_cnt", 64'(wr_cnt - w0), 64'd1);
        chk("part_stall", 64'(stall_cnt - s0), 64'd1);
        chk("part_wr_addr", 64'(last_wr_addr), 64'h030);
        chk("part_wr_data", 64'(last_wr_data), 64'({bpar(32'h112233AA), 32'h112233AA}));
        rd(12'h030);
        idle(2);

        // 4: parity error on read, then on an RMW pre-read
        rd(12'h040);
        idle(2);
        r0 = rmw_cnt;
        do_op(1'b1, 12'h040, 32'h000000CC, 32'h000000FF, g1);
        idle(2);
        chk("rmw_err_pulse", 64'(rmw_cnt - r0), 64'd1);
        chk("rmw_fixed_word", 64'(mem[12'h040]), 64'({bpar(32'h556677CC), 32'h556677CC}));
        rd(12'h040);
        idle(2);
        // bad byte fully overwritten: no error reported
        r0 = rmw_cnt;
        do_op(1'b1, 12'h050, 32'h00EE0000, 32'h00FF0000, g1);
        idle(2);
        chk("rmw_no_err", 64'(rmw_cnt - r0), 64'd0);
        chk("rmw_word2", 64'(mem[12'h050]), 64'({bpar(32'h99EEBBCC), 32'h99EEBBCC}));

        // 5: partial write immediately followed by read of same word
        do_op(1'b1, 12'h060, 32'h0000BB00, 32'h0000FF00, g1);
        do_op(1'b0, 12'h060, 32'h0, 32'h0, g2);
        idle(2);
        chk("rd_after_rmw_stall", 64'(g2 - g1), 64'd2);

        // back-to-back reads
        rd(12'h010);
        rd(12'h020);
        rd(12'h030);
        idle(2);

        // 6: reset during MERGE drops the write
        sav = ref_data[12'h070];
        w0 = wr_cnt;
        do_op(1'b1, 12'h070, 32'h00000011, 32'h000000FF, g1);
        @(posedge clk); #1;
        req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("merge_rst_mem_req", 64'(mem_req), 64'd0);
        chk("merge_rst_gnt", 64'(gnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_data[12'h070] = sav;
        idle(1);
        chk("merge_rst_no_wr", 64'(wr_cnt - w0), 64'd0);
        chk("merge_rst_word", 64'(mem[12'h070]), 64'({bpar(32'hCAFEF00D), 32'hCAFEF00D}));
        rd(12'h070);
        idle(2);

        // null write: granted, no macro access
        a0 = acc_cnt;
        do_op(1'b1, 12'h080, 32'hFFFFFFFF, 32'h0, g1);
        chk("null_granted", 64'(g1 >= 0), 64'd1);
        idle(2);
        chk("null_no_access", 64'(acc_cnt - a0), 64'd0);

        idle(3);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
